pacman_life_ctrl: RTL

// Game-flow sequencer for the pacman movement datapath, clocked on the frame tick.

---
 rtl/pacman_pkg.sv | 49 ++++
 rtl/frame_timer.sv | 27 ++
 rtl/pacman_life_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared state encoding, default frame counts and output decode
// for the pacman game-flow sequencer.
package pacman_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_PLAY    = 3'd2,
        S_DYING   = 3'd3,
        S_RESPAWN = 3'd4,
        S_OVER    = 3'd5,
        S_WON     = 3'd6
    } game_state_t;

    localparam int DEF_LIVES_INIT     = 3;
    localparam int DEF_READY_FRAMES   = 120;
    localparam int DEF_DYING_FRAMES   = 90;
    localparam int DEF_RESPAWN_FRAMES = 2;
    localparam int DEF_CNT_W          = 8;
    localparam int DEF_LIVES_W        = 2;

    typedef struct packed {
        logic death;
        logic is_defeated;
        logic game_over;
        logic level_won;
    } flow_out_t;

    // Pacman is frozen in every state except PLAY and RESPAWN.
    function automatic flow_out_t decode_outputs(input game_state_t s);
        flow_out_t o;
        o.death       = 1'b1;
        o.is_defeated = 1'b0;
        o.game_over   = 1'b0;
        o.level_won   = 1'b0;
        case (s)
            S_PLAY:    o.death = 1'b0;
            S_RESPAWN: begin
                o.death       = 1'b0;
                o.is_defeated = 1'b1;
            end
            S_OVER:    o.game_over = 1'b1;
            S_WON:     o.level_won = 1'b1;
            default:   ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Down-counting frame timer: load has priority, decrement stops at zero.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             frame_clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pacman_life_ctrl.sv
// Game-flow sequencer: lives, ready/dying/respawn delays, game-over and
// level-won, driving the pacman block's death and isDefeated inputs.
module pacman_life_ctrl
    import pacman_pkg::*;
#(
    parameter int LIVES_INIT     = DEF_LIVES_INIT,
    parameter int READY_FRAMES   = DEF_READY_FRAMES,
    parameter int DYING_FRAMES   = DEF_DYING_FRAMES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int LIVES_W        = DEF_LIVES_W
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               collision,
    input  logic               pellets_cleared,
    input  logic               hasMoved,
    output logic               death,
    output logic               isDefeated,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               level_won,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0]   READY_LOAD   = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   DYING_LOAD   = CNT_W'(DYING_FRAMES - 1);
    localparam logic [CNT_W-1:0]   RESPAWN_LOAD = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_LOAD   = LIVES_W'(LIVES_INIT);

    game_state_t      state_q, state_nx;
    logic [LIVES_W-1:0] lives_nx;
    logic             start_q, start_rise;
    logic             t_load, t_dec, t_zero;
    logic [CNT_W-1:0] t_val;

    assign start_rise = start & ~start_q;
    assign state      = state_q;

    frame_timer #(.CNT_W(CNT_W)) u_timer (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (t_load),
        .load_val  (t_val),
        .dec       (t_dec),
        .zero      (t_zero)
    );

    // Every delayed state reloads the timer on entry, so it never wraps.
    always_comb begin
        state_nx = state_q;
        lives_nx = lives;
        t_load   = 1'b0;
        t_val    = '0;
        t_dec    = 1'b0;
        case (state_q)
            S_IDLE: if (start_rise) begin
                state_nx = S_RESPAWN;
                t_load   = 1'b1;
                t_val    = RESPAWN_LOAD;
            end
            S_RESPAWN: if (t_zero) begin
                state_nx = S_READY;
                t_load   = 1'b1;
                t_val    = READY_LOAD;
            end else begin
                t_dec = 1'b1;
            end
            S_READY: if (t_zero) state_nx = S_PLAY;
                     else        t_dec    = 1'b1;
            S_PLAY: if (pellets_cleared) begin
                state_nx = S_WON;
            end else if (collision && hasMoved) begin
                state_nx = S_DYING;
                t_load   = 1'b1;
                t_val    = DYING_LOAD;
                lives_nx = (lives == '0) ? '0 : lives - LIVES_W'(1);
            end
            S_DYING: if (t_zero) begin
                if (lives == '0) begin
                    state_nx = S_OVER;
                end else begin
                    state_nx = S_RESPAWN;
                    t_load   = 1'b1;
                    t_val    = RESPAWN_LOAD;
                end
            end else begin
                t_dec = 1'b1;
            end
            S_OVER: if (start_rise) begin
                state_nx = S_RESPAWN;
                lives_nx = LIVES_LOAD;
                t_load   = 1'b1;
                t_val    = RESPAWN_LOAD;
            end
            S_WON: if (start_rise) begin
                state_nx = S_RESPAWN;
                t_load   = 1'b1;
                t_val    = RESPAWN_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            lives      <= LIVES_LOAD;
            start_q    <= 1'b0;
            death      <= 1'b1;
            isDefeated <= 1'b0;
            game_over  <= 1'b0;
            level_won  <= 1'b0;
        end else begin
            state_q <= state_nx;
            lives   <= lives_nx;
            start_q <= start;
            {death, isDefeated, game_over, level_won} <= decode_outputs(state_nx);
        end
    end

endmodule
